// File: rtl/gmii_tx_framer.sv
// GMII transmit framer: wraps a raw egress byte stream with preamble/SFD, zero padding,
// CRC-32 FCS and an enforced inter-frame gap. One instance per port.
module gmii_tx_framer #(
  parameter int unsigned MIN_FRAME = 60,
  parameter int unsigned IFG_BYTES = 12
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  output logic [7:0]  gmii_txd,
  output logic        gmii_tx_en,
  output logic        gmii_tx_er,
  output logic        busy,
  output logic [15:0] tx_frames,
  output logic [15:0] tx_aborts
);

  typedef enum logic [2:0] {
    StIdle, StPreamble, StSfd, StData, StPad, StFcs, StAbort, StIfg
  } state_e;

  localparam logic [7:0] IfgMax = 8'(IFG_BYTES);

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int k = 0; k < 8; k++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;   // preamble index, FCS index or IFG low-cycle count
  logic [15:0] byte_cnt_q, byte_cnt_d;
  logic        last_q, last_d;
  logic [31:0] crc_q, crc_d;
  logic [7:0]  txd_q, txd_d;
  logic        en_q, en_d;
  logic        er_q, er_d;
  logic [15:0] frames_q, frames_d;
  logic [15:0] aborts_q, aborts_d;

  logic [31:0] crc_upd;
  logic [31:0] fcs_sh;
  logic [15:0] byte_cnt_inc;
  logic [7:0]  ifg_inc;

  // CRC state always trails the byte currently on the wire; crc_upd folds it in.
  assign crc_upd      = crc_step(crc_q, txd_q);
  assign fcs_sh       = (~crc_q) >> {cnt_q[1:0] + 2'd1, 3'b000};
  assign byte_cnt_inc = (byte_cnt_q == 16'hFFFF) ? byte_cnt_q : byte_cnt_q + 16'd1;
  assign ifg_inc      = (cnt_q >= IfgMax) ? cnt_q : cnt_q + 8'd1;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    byte_cnt_d = byte_cnt_q;
    last_d     = last_q;
    crc_d      = crc_q;
    txd_d      = 8'h00;
    en_d       = 1'b0;
    er_d       = 1'b0;
    frames_d   = frames_q;
    aborts_d   = aborts_q;
    unique case (state_q)
      StIdle: begin
        if (s_valid) begin
          state_d = StPreamble;
          txd_d   = 8'h55;
          en_d    = 1'b1;
          cnt_d   = 8'd0;
          crc_d   = 32'hFFFFFFFF;
        end
      end
      StPreamble: begin
        en_d = 1'b1;
        if (cnt_q == 8'd6) begin
          state_d = StSfd;
          txd_d   = 8'hD5;
        end else begin
          txd_d = 8'h55;
          cnt_d = cnt_q + 8'd1;
        end
      end
      StSfd, StData, StPad: begin
        if (state_q != StSfd) crc_d = crc_upd;
        en_d = 1'b1;
        if (state_q == StPad || (state_q == StData && last_q)) begin
          if (32'(byte_cnt_q) < MIN_FRAME) begin
            state_d    = StPad;
            byte_cnt_d = byte_cnt_inc;
          end else begin
            state_d = StFcs;
            txd_d   = ~crc_upd[7:0];
            cnt_d   = 8'd0;
          end
        end else if (s_valid) begin
          state_d    = StData;
          txd_d      = s_data;
          last_d     = s_last;
          byte_cnt_d = (state_q == StSfd) ? 16'd1 : byte_cnt_inc;
        end else begin
          state_d  = StAbort;
          er_d     = 1'b1;
          cnt_d    = 8'd0;
          aborts_d = aborts_q + 16'd1;
        end
      end
      StFcs: begin
        if (cnt_q == 8'd3) begin
          state_d  = StIfg;
          cnt_d    = 8'd1;
          frames_d = frames_q + 16'd1;
        end else begin
          en_d  = 1'b1;
          txd_d = fcs_sh[7:0];
          cnt_d = cnt_q + 8'd1;
        end
      end
      StAbort: begin
        // Gap counting overlaps the drain of the abandoned frame.
        cnt_d = ifg_inc;
        if (s_valid && s_last) state_d = StIfg;
      end
      StIfg: begin
        if (cnt_q >= IfgMax) begin
          if (s_valid) begin
            state_d = StPreamble;
            txd_d   = 8'h55;
            en_d    = 1'b1;
            cnt_d   = 8'd0;
            crc_d   = 32'hFFFFFFFF;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q    <= StIdle;
      cnt_q      <= 8'd0;
      byte_cnt_q <= 16'd0;
      last_q     <= 1'b0;
      crc_q      <= 32'd0;
      txd_q      <= 8'h00;
      en_q       <= 1'b0;
      er_q       <= 1'b0;
      frames_q   <= 16'd0;
      aborts_q   <= 16'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      byte_cnt_q <= byte_cnt_d;
      last_q     <= last_d;
      crc_q      <= crc_d;
      txd_q      <= txd_d;
      en_q       <= en_d;
      er_q       <= er_d;
      frames_q   <= frames_d;
      aborts_q   <= aborts_d;
    end
  end

  assign s_ready    = (state_q == StSfd) || (state_q == StAbort) ||
                      (state_q == StData && !last_q);
  assign busy       = (state_q != StIdle);
  assign gmii_txd   = txd_q;
  assign gmii_tx_en = en_q;
  assign gmii_tx_er = er_q;
  assign tx_frames  = frames_q;
  assign tx_aborts  = aborts_q;

endmodule
